// File: rtl/serializer_pkg.sv
// Shared types and defaults for the sample serializer slice.
package serializer_pkg;

  localparam int DATA_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding samples between the filter strobe and the serial link.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module sample_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= din;
  end

  assign dout  = mem_q[rdPtr_q];
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/sample_serializer.sv
// Buffers decimated filter samples and ships each one as a framed, MSB-first serial word.
module sample_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_valid,
  output logic                          sclk,
  output logic                          sdo,
  output logic                          fs,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BW = $clog2(DATA_W);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [BW-1:0] BIT_MSB  = BW'(DATA_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);

  state_e              state_q, state_d;
  logic [BW-1:0]       bitCnt_q, bitCnt_d;
  logic [DW-1:0]       divCnt_q, divCnt_d;
  logic [DATA_W-1:0]   shiftReg_q, shiftReg_d;
  logic                overflow_q, overflow_d;
  logic                sclk_q, sclk_d;
  logic                sdo_q, sdo_d;
  logic                fs_q, fs_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   fifoDout;
  logic                fifoFull;
  logic                fifoEmpty;
  logic                popEn;
  logic                pushEn;

  // A pop frees a slot, so a full FIFO still accepts a sample on the pop cycle.
  assign popEn  = (state_q == IDLE) && !fifoEmpty;
  assign pushEn = sample_valid && (!fifoFull || popEn);

  sample_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pushEn),
    .pop   (popEn),
    .din   (sample_in),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .level (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    divCnt_d   = divCnt_q;
    shiftReg_d = shiftReg_q;
    overflow_d = overflow_q | (sample_valid & ~pushEn);

    case (state_q)
      IDLE: begin
        if (popEn) begin
          shiftReg_d = fifoDout;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        bitCnt_d = BIT_MSB;
        divCnt_d = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (divCnt_q == DIV_LAST) begin
          divCnt_d = '0;
          if (bitCnt_q == '0) state_d = GAP;
          else                bitCnt_d = bitCnt_q - 1'b1;
        end else begin
          divCnt_d = divCnt_q + 1'b1;
        end
      end
      GAP: begin
        if (divCnt_q == DIV_LAST) begin
          divCnt_d = '0;
          state_d  = IDLE;
        end else begin
          divCnt_d = divCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line outputs are derived from next-state values so the registers line up with the state.
    sclk_d = (state_d == SHIFT) && (divCnt_d >= DIV_HALF);
    sdo_d  = (state_d == SHIFT) && shiftReg_d[bitCnt_d];
    fs_d   = (state_d == SHIFT) && (bitCnt_d == BIT_MSB);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      divCnt_q   <= '0;
      shiftReg_q <= '0;
      overflow_q <= 1'b0;
      sclk_q     <= 1'b0;
      sdo_q      <= 1'b0;
      fs_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      divCnt_q   <= divCnt_d;
      shiftReg_q <= shiftReg_d;
      overflow_q <= overflow_d;
      sclk_q     <= sclk_d;
      sdo_q      <= sdo_d;
      fs_q       <= fs_d;
      busy_q     <= busy_d;
    end
  end

  assign sclk     = sclk_q;
  assign sdo      = sdo_q;
  assign fs       = fs_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Bench for sample_serializer: a frame-level reference model predicts every output each cycle,
// and a serial decoder rebuilds words from sdo on sclk rising edges.
module tb_sample_serializer;

  localparam int DATA_W   = 12;
  localparam int DEPTH    = 4;
  localparam int CLK_DIV  = 2;
  localparam int BIT_LEN  = 2 * CLK_DIV;
  localparam int BUSY_LEN = 1 + (DATA_W + 1) * BIT_LEN;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] sampleIn = '0;
  logic              sampleValid = 1'b0;
  logic              sclk, sdo, fs, busy, overflow;
  logic [2:0]        fifoLevel;

  int total = 0;
  int bad = 0;

  sample_serializer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sampleIn),
    .sample_valid (sampleValid),
    .sclk         (sclk),
    .sdo          (sdo),
    .fs           (fs),
    .busy         (busy),
    .overflow     (overflow),
    .fifo_level   (fifoLevel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of waiting samples, frame offset mK (-1 = idle, 0 = load cycle).
  int          mQ[$];
  int          sentQ[$];
  int          mK = -1;
  bit          mOvf = 1'b0;
  logic [DATA_W-1:0] mWord = '0;

  always @(posedge clk) begin
    if (rst) begin
      mQ.delete();
      sentQ.delete();
      mK   = -1;
      mOvf = 1'b0;
    end else begin
      if (mK >= 0) begin
        mK++;
        if (mK == BUSY_LEN) mK = -1;
      end else if (mQ.size() > 0) begin
        mWord = DATA_W'(mQ.pop_front());
        sentQ.push_back(int'(mWord));
        mK = 0;
      end
      if (sampleValid) begin
        if (mQ.size() < DEPTH) mQ.push_back(int'(sampleIn));
        else                   mOvf = 1'b1;
      end
    end
  end

  bit   checkOn = 1'b0;
  logic prevSclk = 1'b0;
  int   nBits = 0;
  int   wordsDecoded = 0;
  int   peakLevel = 0;
  logic [DATA_W-1:0] acc = '0;

  // Per-cycle comparison against the model plus word reconstruction from the serial lines.
  always @(negedge clk) begin
    logic es, ed, ef;
    int   j, b;
    if (checkOn) begin
      es = 1'b0; ed = 1'b0; ef = 1'b0;
      if (mK >= 1) begin
        j = mK - 1;
        b = j / BIT_LEN;
        if (b < DATA_W) begin
          es = ((j % BIT_LEN) >= CLK_DIV);
          ed = mWord[DATA_W-1-b];
          ef = (b == 0);
        end
      end
      checkOutput("busy", busy, mK >= 0);
      checkOutput("level", fifoLevel, mQ.size());
      checkOutput("overflow", overflow, mOvf);
      checkOutput("sclk", sclk, es);
      checkOutput("sdo", sdo, ed);
      checkOutput("fs", fs, ef);
      if (int'(fifoLevel) > peakLevel) peakLevel = int'(fifoLevel);

      if (rst) begin
        nBits = 0;
        prevSclk = 1'b0;
      end else begin
        if (sclk && !prevSclk) begin
          if (fs) nBits = 0;
          acc = {acc[DATA_W-2:0], sdo};
          nBits++;
          if (nBits == DATA_W) begin
            nBits = 0;
            wordsDecoded++;
            checkOutput("wordAvail", sentQ.size() > 0, 1);
            if (sentQ.size() > 0) checkOutput("word", acc, sentQ.pop_front());
          end
        end
        prevSclk = sclk;
      end
    end
  end

  task automatic applyStimulus(input logic [DATA_W-1:0] s, input logic v);
    @(negedge clk);
    sampleIn    = s;
    sampleValid = v;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    sampleValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((mK >= 0 || mQ.size() > 0) && n < 2000) begin
      applyStimulus('0, 1'b0);
      n++;
    end
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    checkOutput("drainTimeout", n < 2000, 1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt, lows, n, wordsBefore;

    applyReset();
    checkOn = 1'b1;
    applyStimulus('0, 1'b0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstLevel", fifoLevel, 0);
    checkOutput("rstOvf", overflow, 0);

    // Single word: latency and frame length.
    applyStimulus(12'hA5C, 1'b1);
    applyStimulus('0, 1'b0);
    checkOutput("latLevel", fifoLevel, 1);
    applyStimulus('0, 1'b0);
    checkOutput("latLoadBusy", busy, 1);
    checkOutput("latLoadFs", fs, 0);
    applyStimulus('0, 1'b0);
    checkOutput("latFs", fs, 1);
    checkOutput("latSdo", sdo, 1);
    cnt = 2;
    n = 0;
    while (n < 200) begin
      applyStimulus('0, 1'b0);
      if (!busy) break;
      cnt++;
      n++;
    end
    checkOutput("busyLen", cnt, BUSY_LEN);
    checkOutput("ovfSingle", overflow, 0);
    waitDrain();

    // Two words three cycles apart: one idle cycle between frames.
    applyStimulus(12'h000, 1'b1);
    applyStimulus('0, 1'b0);
    applyStimulus('0, 1'b0);
    applyStimulus(12'hFFF, 1'b1);
    applyStimulus('0, 1'b0);
    n = 0;
    while (busy && n < 200) begin applyStimulus('0, 1'b0); n++; end
    lows = 0;
    while (!busy && n < 400) begin applyStimulus('0, 1'b0); lows++; n++; end
    checkOutput("gapIdle", lows, 1);
    waitDrain();

    // Six consecutive pushes: one dropped.
    peakLevel = 0;
    wordsBefore = wordsDecoded;
    for (int i = 0; i < 6; i++) applyStimulus(DATA_W'(12'h101 * (i + 1)), 1'b1);
    applyStimulus('0, 1'b0);
    waitDrain();
    checkOutput("burstPeak", peakLevel, DEPTH);
    checkOutput("burstOvf", overflow, 1);
    checkOutput("burstWords", wordsDecoded - wordsBefore, 5);

    // Full FIFO with a push landing on the idle pop.
    applyReset();
    for (int i = 0; i < 5; i++) applyStimulus(DATA_W'(12'h3A0 + i), 1'b1);
    applyStimulus('0, 1'b0);
    n = 0;
    while (mK >= 0 && n < 200) begin applyStimulus('0, 1'b0); n++; end
    checkOutput("fullBefore", fifoLevel, DEPTH);
    applyStimulus(12'hABC, 1'b1);
    applyStimulus('0, 1'b0);
    checkOutput("fullPopLevel", fifoLevel, DEPTH);
    checkOutput("fullPopOvf", overflow, 0);
    waitDrain();

    // Reset in the middle of the fifth bit.
    applyStimulus(12'h5A3, 1'b1);
    applyStimulus(12'h0F0, 1'b1);
    applyStimulus('0, 1'b0);
    n = 0;
    while (mK != 2 + 4 * BIT_LEN && n < 200) begin applyStimulus('0, 1'b0); n++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abortSclk", sclk, 0);
    checkOutput("abortSdo", sdo, 0);
    checkOutput("abortFs", fs, 0);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortLevel", fifoLevel, 0);
    applyStimulus(12'h3C6, 1'b1);
    applyStimulus('0, 1'b0);
    waitDrain();

    // Random samples with random spacing, sometimes close enough to overflow.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(DATA_W'($urandom), 1'b1);
      repeat ($urandom_range(0, 70)) applyStimulus('0, 1'b0);
    end
    applyStimulus('0, 1'b0);
    waitDrain();
    checkOutput("drained", sentQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
